// File: rtl/fwd_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// fwd_hazard_scoreboard
//
// Scoreboard-based hazard and forwarding unit that sits beside the ID/EX
// pipeline register.
//
// Each architectural register (except x0) has an entry that records:
//   - whether a write to it is in flight,
//   - how many stages past EX that write currently is,
//   - the result latency of its producer.
//
// At issue time the unit decides whether the instruction in ID must stall.
// A stall is needed when a source's producer has not yet reached the stage
// where its result becomes forwardable. Otherwise the unit picks a forward
// source for each operand. The picks are registered, so they drive the EX
// operand muxes in the following cycle.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pipe_freeze         global freeze; all state holds
//   flush               kills this cycle's candidate issue
//   iss_valid           instruction in ID requests issue
//   iss_rs1/_used       source 1 index and read enable
//   iss_rs2/_used       source 2 index and read enable
//   iss_we, iss_rd      destination write enable and index
//   iss_lat             stages after EX until the result is forwardable
//   hazard_stall        combinational stall request (hold IF/ID, bubble EX)
//   ex_fwd_a/b          registered operand source for the EX instruction
//                       (0 = regfile, k = pipeline register k stages ahead)
//   stall_cnt           saturating count of stall cycles
// -----------------------------------------------------------------------------
module fwd_hazard_scoreboard #(
    parameter int NUM_REGS  = 32,
    parameter int IDX_W     = 5,
    parameter int FWD_DEPTH = 2,
    parameter int SEL_W     = $clog2(FWD_DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pipe_freeze,
    input  logic             flush,
    input  logic             iss_valid,
    input  logic [IDX_W-1:0] iss_rs1,
    input  logic             iss_rs1_used,
    input  logic [IDX_W-1:0] iss_rs2,
    input  logic             iss_rs2_used,
    input  logic             iss_we,
    input  logic [IDX_W-1:0] iss_rd,
    input  logic [SEL_W-1:0] iss_lat,
    output logic             hazard_stall,
    output logic [SEL_W-1:0] ex_fwd_a,
    output logic [SEL_W-1:0] ex_fwd_b,
    output logic [31:0]      stall_cnt
);

    localparam logic [SEL_W:0] DEPTH_C = (SEL_W + 1)'(FWD_DEPTH);

    // Per-register scoreboard. Entry 0 is never written, because the write
    // enable excludes rd == 0, so it stays idle after reset.
    logic             busy_q [NUM_REGS];
    logic             busy_d [NUM_REGS];
    logic [SEL_W:0]   dist_q [NUM_REGS];
    logic [SEL_W:0]   dist_d [NUM_REGS];
    logic [SEL_W-1:0] lat_q  [NUM_REGS];
    logic [SEL_W-1:0] lat_d  [NUM_REGS];

    logic [SEL_W-1:0] fwd_a_q, fwd_a_d;
    logic [SEL_W-1:0] fwd_b_q, fwd_b_d;
    logic [31:0]      stall_cnt_q, stall_cnt_d;

    // Source checks read only the current state, never this cycle's update.
    // As a result, an instruction whose rd equals one of its own sources sees
    // the older producer.
    logic             rs1_hit, rs2_hit;
    logic             rs1_stall, rs2_stall;
    logic [SEL_W-1:0] rs1_sel, rs2_sel;
    logic             accept;
    logic             wr_en;

    assign rs1_hit   = iss_rs1_used && (iss_rs1 != '0) && busy_q[iss_rs1];
    assign rs2_hit   = iss_rs2_used && (iss_rs2 != '0) && busy_q[iss_rs2];
    assign rs1_stall = rs1_hit && (dist_q[iss_rs1] < {1'b0, lat_q[iss_rs1]});
    assign rs2_stall = rs2_hit && (dist_q[iss_rs2] < {1'b0, lat_q[iss_rs2]});

    // A busy entry's distance never exceeds FWD_DEPTH, so it fits in SEL_W bits.
    assign rs1_sel = rs1_hit ? dist_q[iss_rs1][SEL_W-1:0] : '0;
    assign rs2_sel = rs2_hit ? dist_q[iss_rs2][SEL_W-1:0] : '0;

    // Stall does not depend on freeze, so ID sees a stable answer while frozen.
    assign hazard_stall = iss_valid && !flush && !rst && (rs1_stall || rs2_stall);
    assign accept       = iss_valid && !hazard_stall && !flush && !pipe_freeze;
    assign wr_en        = accept && iss_we && (iss_rd != '0);

    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            busy_d[r] = busy_q[r];
            dist_d[r] = dist_q[r];
            lat_d[r]  = lat_q[r];
            // Age in-flight writes. Once a write would move past the last
            // forwarding stage, it has reached the regfile and is retired.
            if (busy_q[r]) begin
                if (dist_q[r] >= DEPTH_C) begin
                    busy_d[r] = 1'b0;
                    dist_d[r] = '0;
                end else begin
                    dist_d[r] = dist_q[r] + 1'b1;
                end
            end
            // A new producer replaces any older in-flight write (WAW).
            if (wr_en && (iss_rd == IDX_W'(r))) begin
                busy_d[r] = 1'b1;
                dist_d[r] = (SEL_W + 1)'(1);
                lat_d[r]  = iss_lat;
            end
        end
    end

    always_comb begin
        fwd_a_d     = accept ? rs1_sel : '0;
        fwd_b_d     = accept ? rs2_sel : '0;
        stall_cnt_d = stall_cnt_q;
        if (hazard_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= 1'b0;
                dist_q[r] <= '0;
                lat_q[r]  <= '0;
            end
            fwd_a_q     <= '0;
            fwd_b_q     <= '0;
            stall_cnt_q <= '0;
        end else if (!pipe_freeze) begin
            for (int r = 0; r < NUM_REGS; r++) begin
                busy_q[r] <= busy_d[r];
                dist_q[r] <= dist_d[r];
                lat_q[r]  <= lat_d[r];
            end
            fwd_a_q     <= fwd_a_d;
            fwd_b_q     <= fwd_b_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign ex_fwd_a  = fwd_a_q;
    assign ex_fwd_b  = fwd_b_q;
    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_fwd_hazard_scoreboard.sv
// -----------------------------------------------------------------------------
// tb_fwd_hazard_scoreboard
//
// Directed testbench for fwd_hazard_scoreboard.
//
// Timing:
//   - Inputs are applied on the falling clock edge.
//   - hazard_stall is checked 1 ns after inputs are applied.
//   - Registered outputs are checked on the next falling edge, after the
//     capturing rising edge.
// -----------------------------------------------------------------------------
module tb_fwd_hazard_scoreboard;

    localparam int NUM_REGS  = 32;
    localparam int IDX_W     = 5;
    localparam int FWD_DEPTH = 2;
    localparam int SEL_W     = 2;

    logic             clk = 1'b0;
    logic             rst;
    logic             pipe_freeze;
    logic             flush;
    logic             iss_valid;
    logic [IDX_W-1:0] iss_rs1;
    logic             iss_rs1_used;
    logic [IDX_W-1:0] iss_rs2;
    logic             iss_rs2_used;
    logic             iss_we;
    logic [IDX_W-1:0] iss_rd;
    logic [SEL_W-1:0] iss_lat;
    logic             hazard_stall;
    logic [SEL_W-1:0] ex_fwd_a;
    logic [SEL_W-1:0] ex_fwd_b;
    logic [31:0]      stall_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    fwd_hazard_scoreboard #(
        .NUM_REGS (NUM_REGS),
        .IDX_W    (IDX_W),
        .FWD_DEPTH(FWD_DEPTH),
        .SEL_W    (SEL_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pipe_freeze (pipe_freeze),
        .flush       (flush),
        .iss_valid   (iss_valid),
        .iss_rs1     (iss_rs1),
        .iss_rs1_used(iss_rs1_used),
        .iss_rs2     (iss_rs2),
        .iss_rs2_used(iss_rs2_used),
        .iss_we      (iss_we),
        .iss_rd      (iss_rd),
        .iss_lat     (iss_lat),
        .hazard_stall(hazard_stall),
        .ex_fwd_a    (ex_fwd_a),
        .ex_fwd_b    (ex_fwd_b),
        .stall_cnt   (stall_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end else begin
            $display("ok   %s: %0d", tag, got);
        end
    endtask

    // Applies one issue candidate, lets the combinational logic settle, and
    // confirms that any accepted instruction carries a legal latency.
    task automatic apply(input logic v, input int rs1, input logic u1,
                         input int rs2, input logic u2,
                         input logic we, input int rd, input int lat);
        iss_valid    = v;
        iss_rs1      = IDX_W'(rs1);
        iss_rs1_used = u1;
        iss_rs2      = IDX_W'(rs2);
        iss_rs2_used = u2;
        iss_we       = we;
        iss_rd       = IDX_W'(rd);
        iss_lat      = SEL_W'(lat);
        #1;
        if (!rst && iss_valid && !flush && !pipe_freeze && !hazard_stall) begin
            assert (iss_lat >= 1 && iss_lat <= FWD_DEPTH)
                else $error("FAIL illegal_lat: got %0d expected 1..%0d", iss_lat, FWD_DEPTH);
        end
    endtask

    task automatic idle();
        apply(1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 0, 1);
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        idle();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b1; pipe_freeze = 1'b0; flush = 1'b0;
        idle();
        step();

        // ---------------- reset state ----------------
        do_reset();
        check("rst_stall", {31'd0, hazard_stall}, 32'd0);
        check("rst_fwd_a", 32'(ex_fwd_a), 32'd0);
        check("rst_fwd_b", 32'(ex_fwd_b), 32'd0);
        check("rst_cnt",   stall_cnt, 32'd0);

        // ---------------- ALU back-to-back ----------------
        apply(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 5, 1);      // x5 <- alu
        check("alu_prod_stall", {31'd0, hazard_stall}, 32'd0);
        step();
        apply(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 0, 1);      // use x5
        check("alu_cons_stall", {31'd0, hazard_stall}, 32'd0);
        step();
        idle();
        check("alu_fwd_a", 32'(ex_fwd_a), 32'd1);
        check("alu_fwd_b", 32'(ex_fwd_b), 32'd0);

        // ---------------- load-use ----------------
        do_reset();
        apply(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 7, 2);      // lw x7
        step();
        apply(1'b1, 0, 1'b0, 7, 1'b1, 1'b1, 8, 1);      // use x7 as rs2
        check("lu_stall_c1", {31'd0, hazard_stall}, 32'd1);
        step();
        check("lu_bubble_b", 32'(ex_fwd_b), 32'd0);
        check("lu_stall_c2", {31'd0, hazard_stall}, 32'd0);
        step();
        idle();
        check("lu_fwd_b", 32'(ex_fwd_b), 32'd2);
        check("lu_cnt",   stall_cnt, 32'd1);

        // ---------------- retirement and x0 ----------------
        do_reset();
        apply(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 9, 1);      // x9 <- alu, c0
        step();
        idle();                                          // c1
        step();
        apply(1'b1, 9, 1'b1, 0, 1'b0, 1'b0, 0, 1);      // c2, dist 2
        step();
        check("ret_fwd_a_dist2", 32'(ex_fwd_a), 32'd2);
        apply(1'b1, 9, 1'b1, 0, 1'b0, 1'b0, 0, 1);      // c3, retired
        check("ret_stall", {31'd0, hazard_stall}, 32'd0);
        step();
        check("ret_fwd_a", 32'(ex_fwd_a), 32'd0);
        apply(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 0, 2);      // load to x0
        step();
        apply(1'b1, 0, 1'b1, 0, 1'b1, 1'b0, 0, 1);      // read x0
        check("x0_stall", {31'd0, hazard_stall}, 32'd0);
        step();
        idle();
        check("x0_fwd_a", 32'(ex_fwd_a), 32'd0);
        check("x0_fwd_b", 32'(ex_fwd_b), 32'd0);

        // ---------------- WAW ----------------
        do_reset();
        apply(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 5, 1);      // x5 alu
        step();
        apply(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 5, 2);      // x5 load
        step();
        apply(1'b1, 5, 1'b1, 0, 1'b0, 1'b0, 0, 1);
        check("waw_stall_c2", {31'd0, hazard_stall}, 32'd1);
        step();
        check("waw_stall_c3", {31'd0, hazard_stall}, 32'd0);
        step();
        idle();
        check("waw_fwd_a", 32'(ex_fwd_a), 32'd2);
        check("waw_cnt",   stall_cnt, 32'd1);

        // ---------------- freeze ----------------
        do_reset();
        apply(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 7, 2);      // lw x7, c0
        step();
        pipe_freeze = 1'b1;
        idle();                                          // c1
        step();
        apply(1'b1, 7, 1'b1, 0, 1'b0, 1'b0, 0, 1);      // c2, frozen consumer
        check("frz_stall", {31'd0, hazard_stall}, 32'd1);
        step();
        idle();                                          // c3
        step();
        pipe_freeze = 1'b0;
        check("frz_cnt_hold", stall_cnt, 32'd0);
        apply(1'b1, 7, 1'b1, 0, 1'b0, 1'b0, 0, 1);      // c4, dist still 1
        check("frz_stall_c4", {31'd0, hazard_stall}, 32'd1);
        step();
        check("frz_stall_c5", {31'd0, hazard_stall}, 32'd0);
        step();
        idle();
        check("frz_fwd_a", 32'(ex_fwd_a), 32'd2);
        check("frz_cnt",   stall_cnt, 32'd1);

        // ---------------- flush ----------------
        do_reset();
        apply(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 7, 2);      // lw x7
        step();
        flush = 1'b1;
        apply(1'b1, 7, 1'b1, 0, 1'b0, 1'b1, 10, 1);     // hazardous, flushed
        check("fl_stall", {31'd0, hazard_stall}, 32'd0);
        step();
        flush = 1'b0;
        check("fl_fwd_a", 32'(ex_fwd_a), 32'd0);
        apply(1'b1, 0, 1'b0, 10, 1'b1, 1'b0, 0, 1);     // x10 must be idle
        check("fl_x10_stall", {31'd0, hazard_stall}, 32'd0);
        step();
        idle();
        check("fl_x10_fwd_b", 32'(ex_fwd_b), 32'd0);
        check("fl_cnt", stall_cnt, 32'd0);

        // ---------------- self-dependent loads, then reset mid-flight ----------------
        do_reset();
        apply(1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 7, 2);      // lw x7
        step();
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 7, 1'b1, 0, 1'b0, 1'b1, 7, 2);  // lw x7, 0(x7)
            check($sformatf("self_stall_%0d", i), {31'd0, hazard_stall}, 32'd1);
            step();
            check($sformatf("self_go_%0d", i), {31'd0, hazard_stall}, 32'd0);
            step();
            check($sformatf("self_fwd_a_%0d", i), 32'(ex_fwd_a), 32'd2);
        end
        check("mid_cnt", stall_cnt, 32'd5);
        rst = 1'b1;
        apply(1'b1, 7, 1'b1, 0, 1'b0, 1'b1, 7, 2);
        check("mid_rst_stall", {31'd0, hazard_stall}, 32'd0);
        step();
        rst = 1'b0;
        check("mid_rst_fwd_a", 32'(ex_fwd_a), 32'd0);
        check("mid_rst_fwd_b", 32'(ex_fwd_b), 32'd0);
        check("mid_rst_cnt",   stall_cnt, 32'd0);
        apply(1'b1, 7, 1'b1, 7, 1'b1, 1'b0, 0, 1);
        check("post_rst_stall", {31'd0, hazard_stall}, 32'd0);
        step();
        idle();
        check("post_rst_fwd_a", 32'(ex_fwd_a), 32'd0);
        check("post_rst_fwd_b", 32'(ex_fwd_b), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog: the directed sequence is short, so this limit only matters if
    // the bench itself stops making progress.
    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
